fault_detector: RTL and testbench
=================================

Name: fault_detector

Overview:
Debouncing, prioritising fault supervisor for a power stage. It takes four raw fault flags plus a per-bit mask and runs a NORMAL / WARNING / FAULT state machine. The current state is reported on a 2-bit status output. It sits between the analog comparator/status logic and the system shutdown controller.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive sampled edges a non-critical fault must be active before NORMAL->WARNING
PERSIST_CYCLES, 16, consecutive edges in WARNING with the fault still active before WARNING->FAULT
CNT_W, 5, width of both internal counters; must hold max(DEBOUNCE_CYCLES, PERSIST_CYCLES)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
fault_flags  input  4  raw faults, synchronous to clk: [0] undervoltage, [1] overtemp, [2] overvoltage, [3] overcurrent
mask_reg  input  4  per-bit mask; 1 = corresponding fault ignored
y  output  2  state code: 00 NORMAL, 01 WARNING, 10 FAULT, 11 never driven

Behaviour:
- Fault qualification:
  - active = fault_flags & ~mask_reg, evaluated combinationally every cycle.
  - Mask changes take effect at the next rising edge.
  - crit = active[3] | active[2].
  - noncrit = active[1] | active[0].
- Internal registers, visible to the bench by hierarchy:
  - state: enumerated type with members NORMAL, WARNING, FAULT; .name() is usable.
  - debounce_counter [CNT_W-1:0].
  - persistence_counter [CNT_W-1:0].
- y is a registered decode of state, with no extra latency: y changes on the same edge as state.
- Reset (reset==0, asynchronous): state=NORMAL, y=00, both counters 0. Reset mid-operation aborts any count immediately.
- NORMAL:
  - crit -> FAULT on the next edge; both counters cleared. crit has priority over everything.
  - else if noncrit: debounce_counter increments each edge. On the edge where noncrit has been sampled DEBOUNCE_CYCLES consecutive times -> WARNING; debounce_counter cleared.
  - else: debounce_counter cleared. A pulse shorter than DEBOUNCE_CYCLES edges never leaves NORMAL.
- WARNING:
  - crit -> FAULT next edge; counters cleared.
  - else if noncrit: persistence_counter increments. On the PERSIST_CYCLES-th consecutive active edge -> FAULT; counter cleared.
  - else (fault gone or masked) -> NORMAL next edge; both counters cleared.
- FAULT:
  - Latched; only reset exits.
  - Counters held at 0.
  - Flag or mask changes have no effect.
- Counters never wrap: the state transitions before terminal count is exceeded.
- Counter behaviour does not depend on which non-critical bit is active; bits may swap while noncrit stays 1.
- Simultaneous crit and noncrit: the crit path wins.
- All-masked flags behave exactly like flags=0.

Test Plan:
- Reset low, flags=0000, mask=0000 -> state NORMAL, y=00, counters 0. Release reset; stays NORMAL for 10 cycles.
- Flag[0]=1 for 1-2 cycles, then 0 -> y stays 00; debounce_counter returns to 0; never enters WARNING.
- Flag[1]=1 held 25 cycles:
  - y=01 after exactly 3 edges.
  - persistence_counter counts 1..15.
  - y=10 after 16 further edges.
  - Clear flag -> y stays 10 until reset.
- From NORMAL, flag[1]=1 for 5 edges (WARNING), then 0 -> returns to y=00 next edge; counters 0.
- After reset, flag[3]=1 -> y=10 on the first edge; same for flag[2]. Assert reset mid-FAULT -> y=00 immediately, without waiting for an edge.
- mask=0100, flag[2]=1 -> y stays 00 indefinitely. Clear the mask -> y=10 next edge. Mask set while already in FAULT -> y stays 10.

Source files
------------

// File: rtl/fault_detector.sv
`default_nettype none
// ============================================================================
//  Module   : fault_detector
//  Purpose  : Debouncing, prioritising fault supervisor for a power stage.
//             Four raw fault flags are qualified by a per-bit mask and drive
//             a NORMAL / WARNING / FAULT state machine. Critical faults
//             (overcurrent, overvoltage) go straight to FAULT. Non-critical
//             faults (overtemp, undervoltage) must first survive a debounce
//             window to reach WARNING. They must then persist long enough
//             to escalate to FAULT. FAULT is latched until reset.
//  Ports    : clk          - rising-edge clock
//             reset        - asynchronous active-low reset
//             fault_flags  - [0] UV, [1] OT, [2] OV, [3] OC (synchronous)
//             mask_reg     - 1 = corresponding fault ignored
//             y            - state code: 00 NORMAL, 01 WARNING, 10 FAULT
//  Revision : 1.0 - initial release
// ============================================================================
module fault_detector #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int PERSIST_CYCLES  = 16,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] fault_flags,
   input  logic [3:0] mask_reg,
   output logic [1:0] y
);

   typedef enum logic [1:0] {
      NORMAL  = 2'b00,
      WARNING = 2'b01,
      FAULT   = 2'b10
   } state_t;

   // Counter value at which the next active edge completes the window.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERSIST_CYCLES - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] debounce_counter;
   logic [CNT_W-1:0] debounce_next;
   logic [CNT_W-1:0] persistence_counter;
   logic [CNT_W-1:0] persistence_next;
   logic [1:0]       y_next;

   logic [3:0] active;
   logic       crit;
   logic       noncrit;

   assign active  = fault_flags & ~mask_reg;
   assign crit    = active[3] | active[2];
   assign noncrit = active[1] | active[0];

   // ------------------------------------------------------------------------
   // State and counter registers. y is registered from the next-state
   // decode so it changes on the same edge as state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= NORMAL;
         debounce_counter    <= '0;
         persistence_counter <= '0;
         y                   <= 2'b00;
      end else begin
         state               <= next_state;
         debounce_counter    <= debounce_next;
         persistence_counter <= persistence_next;
         y                   <= y_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and counter logic. Counters are cleared on every state
   // change, so each window restarts from zero.
   // ------------------------------------------------------------------------
   always_comb begin
      next_state       = state;
      debounce_next    = '0;
      persistence_next = '0;

      case (state)
         NORMAL: begin
            if (crit) begin
               next_state = FAULT;
            end else if (noncrit) begin
               if (debounce_counter == DEB_LAST) begin
                  next_state = WARNING;
               end else begin
                  debounce_next = debounce_counter + 1'b1;
               end
            end
         end

         WARNING: begin
            if (crit) begin
               next_state = FAULT;
            end else if (noncrit) begin
               if (persistence_counter == PER_LAST) begin
                  next_state = FAULT;
               end else begin
                  persistence_next = persistence_counter + 1'b1;
               end
            end else begin
               next_state = NORMAL;
            end
         end

         FAULT: begin
            next_state = FAULT;
         end

         default: begin
            // Unreachable encoding: fail safe into the latched fault state.
            next_state = FAULT;
         end
      endcase
   end

   always_comb begin
      y_next = 2'b00;
      case (next_state)
         NORMAL:  y_next = 2'b00;
         WARNING: y_next = 2'b01;
         FAULT:   y_next = 2'b10;
         default: y_next = 2'b10;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_fault_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fault_detector
//  Purpose  : Self-checking bench for fault_detector. A behavioural model
//             predicts state, y and both counters for every clock edge. The
//             predictions go through a scoreboard queue and are compared
//             after each edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fault_detector;

   localparam int DEB = 3;
   localparam int PER = 16;

   logic       clk;
   logic       reset;
   logic [3:0] fault_flags;
   logic [3:0] mask_reg;
   logic [1:0] y;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0] y;
      int         st;
      int         db;
      int         pc;
   } exp_t;

   exp_t sb[$];

   // model state: 0 NORMAL, 1 WARNING, 2 FAULT
   int m_st = 0;
   int m_db = 0;
   int m_pc = 0;

   fault_detector #(
      .DEBOUNCE_CYCLES(DEB),
      .PERSIST_CYCLES (PER),
      .CNT_W          (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fault_flags(fault_flags),
      .mask_reg   (mask_reg),
      .y          (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] code_of(input int st);
      if (st == 0) return 2'b00;
      if (st == 1) return 2'b01;
      return 2'b10;
   endfunction

   // Predict the effect of one clock edge with the given inputs.
   task automatic model_edge(input logic [3:0] f, input logic [3:0] m);
      logic [3:0] act;
      logic       c;
      logic       n;
      act = f & ~m;
      c   = act[3] | act[2];
      n   = act[1] | act[0];
      if (m_st == 2) begin
         m_db = 0;
         m_pc = 0;
      end else if (c) begin
         m_st = 2; m_db = 0; m_pc = 0;
      end else if (m_st == 0) begin
         if (n) begin
            if (m_db + 1 >= DEB) begin
               m_st = 1; m_db = 0;
            end else begin
               m_db = m_db + 1;
            end
         end else begin
            m_db = 0;
         end
      end else begin
         if (n) begin
            if (m_pc + 1 >= PER) begin
               m_st = 2; m_pc = 0;
            end else begin
               m_pc = m_pc + 1;
            end
         end else begin
            m_st = 0; m_db = 0; m_pc = 0;
         end
      end
   endtask

   task automatic compare_state(input exp_t e);
      check("y",           32'(y),                       32'(e.y));
      check("state",       32'(dut.state),               32'(e.st));
      check("debounce",    32'(dut.debounce_counter),    32'(e.db));
      check("persistence", 32'(dut.persistence_counter), 32'(e.pc));
   endtask

   // Drive one cycle of stimulus, push the prediction, compare after the edge.
   task automatic step(input logic [3:0] f, input logic [3:0] m);
      exp_t e;
      fault_flags = f;
      mask_reg    = m;
      model_edge(f, m);
      e.y  = code_of(m_st);
      e.st = m_st;
      e.db = m_db;
      e.pc = m_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         compare_state(sb.pop_front());
      end
   endtask

   // Asynchronous reset, asserted between edges and checked before any edge.
   task automatic async_reset();
      exp_t e;
      reset = 1'b0;
      #1;
      m_st = 0; m_db = 0; m_pc = 0;
      e.y = 2'b00; e.st = 0; e.db = 0; e.pc = 0;
      compare_state(e);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset       = 1'b0;
      fault_flags = 4'b0000;
      mask_reg    = 4'b0000;

      // Reset state
      #3;
      async_reset();
      repeat (10) step(4'b0000, 4'b0000);

      // Short UV pulses never leave NORMAL
      repeat (2) step(4'b0001, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);
      step(4'b0001, 4'b0000);
      step(4'b0000, 4'b0000);

      // OT held: WARNING at edge 3, FAULT 16 edges later, then latched
      repeat (25) step(4'b0010, 4'b0000);
      repeat (5)  step(4'b0000, 4'b0000);
      check("latched_fault_y", 32'(y), 32'd2);
      async_reset();

      // WARNING then fault clears -> back to NORMAL
      repeat (5) step(4'b0010, 4'b0000);
      check("warning_y", 32'(y), 32'd1);
      step(4'b0000, 4'b0000);
      check("back_to_normal_y", 32'(y), 32'd0);

      // Critical faults go straight to FAULT
      step(4'b1000, 4'b0000);
      check("oc_fault_y", 32'(y), 32'd2);
      async_reset();
      step(4'b0100, 4'b0000);
      async_reset();

      // Critical during WARNING, and crit together with noncrit
      repeat (4) step(4'b0001, 4'b0000);
      step(4'b1001, 4'b0000);
      async_reset();

      // Masked OV is ignored; unmasking faults next edge; mask in FAULT is moot
      repeat (20) step(4'b0100, 4'b0100);
      step(4'b0100, 4'b0000);
      repeat (3) step(4'b0000, 4'b1111);
      async_reset();

      // Swapping non-critical bits keeps the count running
      for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 4'b0001 : 4'b0010, 4'b0000);
      async_reset();

      // All-masked flags behave like no flags
      repeat (6) step(4'b1111, 4'b1111);

      // Randomised traffic, mostly non-critical, occasional reset out of FAULT
      for (int i = 0; i < 400; i++) begin
         logic [3:0] f;
         logic [3:0] m;
         if (m_st == 2 && $urandom_range(0, 3) == 0) async_reset();
         f = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) != 0) f[3:2] = 2'b00;
         if ($urandom_range(0, 2) != 0) f[1:0] = 2'b01;
         m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         step(f, m);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
